// File: rtl/sp_ram_param.sv
// Single-port RAM with per-lane byte enables, selectable read-during-write
// behaviour, an optional output register and a self-clearing init sequence.
module sp_ram_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            data,
    output logic [DATA_WIDTH-1:0]            q,
    output logic                             q_valid,
    output logic                             init_busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    acc, wr, rd;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   s0_q, s0_d;
    logic                    s0_valid_q, s0_valid_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StInit: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_busy = (state_q == StInit);
    assign acc       = en && !init_busy;
    assign wr        = acc && we;
    assign rd        = acc && !we;
    assign rd_word   = mem[addr];

    // Lanes without an enable keep the stored value, so the whole word is rewritten.
    always_comb begin
        merged = rd_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign mem_we    = !reset && (init_busy || wr);
    assign mem_addr  = init_busy ? ptr_q : addr;
    assign mem_wdata = init_busy ? '0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        s0_d       = s0_q;
        s0_valid_d = 1'b0;
        if (rd) begin
            s0_d       = rd_word;
            s0_valid_d = 1'b1;
        end else if (wr) begin
            if (RDW_MODE == 0) begin
                s0_d       = rd_word;
                s0_valid_d = 1'b1;
            end else if (RDW_MODE == 1) begin
                s0_d       = merged;
                s0_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q       <= '0;
            s0_valid_q <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s0_valid_q <= s0_valid_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s1_q;
        logic                  s1_valid_q;

        // Only capture fresh results so q keeps holding between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q       <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= s0_valid_q;
                if (s0_valid_q) begin
                    s1_q <= s0_q;
                end
            end
        end

        assign q       = s1_q;
        assign q_valid = s1_valid_q;
    end else begin : g_no_out_reg
        assign q       = s0_q;
        assign q_valid = s0_valid_q;
    end

endmodule

// File: tb/tb_sp_ram_param.sv
// Drives six RAM configurations (RDW_MODE 0..2 x OUT_REG 0..1) with shared
// stimulus and compares them against a word-level reference model.
module tb_sp_ram_param;

    localparam int NCFG = 6;
    localparam int NEV  = 1024;

    logic        clk;
    logic        reset;
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] data;

    logic [NCFG-1:0][15:0] q_arr;
    logic [NCFG-1:0]       qv_arr;
    logic [NCFG-1:0]       busy_arr;

    int n_checks;
    int n_errors;
    int cyc;
    int busy_cnt;

    logic [15:0] mdl [16];
    logic [15:0] exp_q [NCFG];
    bit          exp_v [NCFG];
    bit          ev_v  [NCFG][NEV];
    logic [15:0] ev_d  [NCFG][NEV];

    for (genvar c = 0; c < NCFG; c++) begin : g_dut
        sp_ram_param #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(4),
            .BYTE_WIDTH(8),
            .RDW_MODE  (c % 3),
            .OUT_REG   (c / 3)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .we       (we),
            .be       (be),
            .addr     (addr),
            .data     (data),
            .q        (q_arr[c]),
            .q_valid  (qv_arr[c]),
            .init_busy(busy_arr[c])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] lanes);
        logic [15:0] r;
        r = old;
        for (int l = 0; l < 2; l++) begin
            if (lanes[l]) r[l*8 +: 8] = nw[l*8 +: 8];
        end
        return r;
    endfunction

    // Apply one cycle of stimulus, advance the model by one edge and compare.
    task automatic step(input logic r, input logic e, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] d);
        logic [15:0] oldw, neww;
        int          slot;
        reset = r; en = e; we = w; be = b; addr = a; data = d;
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            for (int i = 0; i < 16; i++) mdl[i] = '0;
            busy_cnt = 16;
            for (int c = 0; c < NCFG; c++) begin
                exp_q[c] = '0;
                exp_v[c] = 1'b0;
                ev_v[c][cyc % NEV]       = 1'b0;
                ev_v[c][(cyc + 1) % NEV] = 1'b0;
            end
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
            end else if (e) begin
                oldw = mdl[a];
                neww = w ? merge(oldw, d, b) : oldw;
                mdl[a] = neww;
                for (int c = 0; c < NCFG; c++) begin
                    slot = (cyc + c / 3) % NEV;
                    if (!w || (c % 3) != 2) begin
                        ev_v[c][slot] = 1'b1;
                        ev_d[c][slot] = (w && (c % 3) == 1) ? neww : oldw;
                    end
                end
            end
            for (int c = 0; c < NCFG; c++) begin
                exp_v[c] = ev_v[c][cyc % NEV];
                if (exp_v[c]) exp_q[c] = ev_d[c][cyc % NEV];
                ev_v[c][cyc % NEV] = 1'b0;
            end
        end
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("q[c%0d]", c), 32'(q_arr[c]), 32'(exp_q[c]));
            check($sformatf("q_valid[c%0d]", c), 32'(qv_arr[c]), 32'(exp_v[c]));
            check($sformatf("init_busy[c%0d]", c), 32'(busy_arr[c]), 32'(busy_cnt > 0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 4'(i), 16'(i));
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 4'(i), 16'hdead);
        idle(2);
    endtask

    initial begin
        int busy_seen;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        busy_cnt = 0;
        for (int c = 0; c < NCFG; c++) begin
            exp_q[c] = '0;
            exp_v[c] = 1'b0;
            for (int k = 0; k < NEV; k++) ev_v[c][k] = 1'b0;
        end
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        reset = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; data = '0;

        // Reset, then the clear sequence must keep init_busy high for 16 samples.
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 2'b11, 4'd1, 16'hffff);
        busy_seen = busy_arr[0] ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'b11, 4'(i), 16'hbeef);
            if (busy_arr[0]) busy_seen++;
        end
        check("init_len", 32'(busy_seen), 32'd16);
        read_all();

        // Full write then read of addr 3.
        step(1'b0, 1'b1, 1'b1, 2'b11, 4'd3, 16'ha5c3);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
        check("a5c3_lat1", 32'(q_arr[0]), 32'h0000a5c3);
        idle(1);
        check("a5c3_lat2", 32'(q_arr[3]), 32'h0000a5c3);
        // Lane-0 only write, then a be=0 write that must change nothing.
        step(1'b0, 1'b1, 1'b1, 2'b01, 4'd3, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
        check("a534", 32'(q_arr[0]), 32'h0000a534);
        step(1'b0, 1'b1, 1'b1, 2'b00, 4'd3, 16'h5555);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
        check("a534_be0", 32'(q_arr[0]), 32'h0000a534);
        idle(2);

        // Read-during-write on addr 5 in all modes.
        step(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'h0f0f);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
        step(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'hffff);
        check("rdw_mode0", 32'(q_arr[0]), 32'h00000f0f);
        check("rdw_mode1", 32'(q_arr[1]), 32'h0000ffff);
        check("rdw_mode2", 32'(q_arr[2]), 32'h0000a534);
        idle(2);

        // Random fill then back-to-back reads.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 2'b11, 4'(i), 16'($urandom));
        read_all();

        // Reset mid-READY, then again at INIT cycle 7.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 2'($urandom), 4'(i), 16'($urandom));
        step(1'b1, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
        busy_seen = 0;
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'b11, 4'(i), 16'hcafe);
            if (busy_arr[0]) busy_seen++;
        end
        check("reinit_len", 32'(busy_seen), 32'd15);
        read_all();

        // Random mixed traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 80) == 0, ($urandom % 4) != 0, 1'($urandom),
                 2'($urandom), 4'($urandom), 16'($urandom));
        end
        idle(20);
        read_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
